// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single main-memory port between the write buffer and the
// dcache/icache read-miss paths. Fixed priority with primary/secondary swap, starvation
// protection for reads, and a one-cycle done pulse per requester.
module mem_arbiter #(
  parameter int unsigned STARVE = 8,
  parameter int unsigned CW     = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        swc,
  input  logic        wbreq,
  input  logic [29:0] wbadr,
  input  logic [31:0] wbdata,
  input  logic [3:0]  wbbyteen,
  input  logic        dreq,
  input  logic [29:0] dadr,
  input  logic        ireq,
  input  logic [29:0] iadr,
  output logic        wbdone,
  output logic        ddone,
  output logic        idone,
  output logic [31:0] rdata,
  output logic [29:0] memadr,
  output logic [31:0] memwdata,
  output logic [3:0]  membyteen,
  output logic        memrwb,
  output logic        memen,
  input  logic [31:0] memrdata,
  input  logic        memdone,
  output logic        busy
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StAck} state_e;
  typedef enum logic [1:0] {GntWb, GntD, GntI} gnt_e;

  state_e        r_state, w_state_next;
  gnt_e          r_grant, w_gnt, w_p_gnt, w_s_gnt;
  logic [CW-1:0] r_dwait, r_iwait;
  logic          w_d_starve, w_i_starve;
  logic          w_p_req, w_s_req, w_p_starve, w_s_starve;
  logic          w_any_req, w_grant_en, w_d_owner, w_i_owner;
  logic [29:0]   r_memadr;
  logic [31:0]   r_memwdata;
  logic [3:0]    r_membyteen;
  logic          r_memrwb;
  logic [31:0]   r_rdata;

  assign memadr    = r_memadr;
  assign memwdata  = r_memwdata;
  assign membyteen = r_membyteen;
  assign memrwb    = r_memrwb;
  assign rdata     = r_rdata;

  assign w_any_req  = wbreq | dreq | ireq;
  assign w_grant_en = (r_state == StIdle) && w_any_req;
  // A requester whose transaction is in flight is being served, so it is not waiting.
  assign w_d_owner  = (r_state != StIdle) && (r_grant == GntD);
  assign w_i_owner  = (r_state != StIdle) && (r_grant == GntI);

  // Winner selection: starving primary > starving secondary > wb > primary > secondary.
  always_comb begin
    w_d_starve = (r_dwait >= CW'(STARVE));
    w_i_starve = (r_iwait >= CW'(STARVE));
    w_p_req    = swc ? ireq : dreq;
    w_s_req    = swc ? dreq : ireq;
    w_p_starve = swc ? w_i_starve : w_d_starve;
    w_s_starve = swc ? w_d_starve : w_i_starve;
    w_p_gnt    = swc ? GntI : GntD;
    w_s_gnt    = swc ? GntD : GntI;
    w_gnt      = GntWb;
    if (w_p_req && w_p_starve) begin
      w_gnt = w_p_gnt;
    end else if (w_s_req && w_s_starve) begin
      w_gnt = w_s_gnt;
    end else if (wbreq) begin
      w_gnt = GntWb;
    end else if (w_p_req) begin
      w_gnt = w_p_gnt;
    end else if (w_s_req) begin
      w_gnt = w_s_gnt;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:  if (w_any_req) w_state_next = StReq;
      StReq:   if (!memdone) w_state_next = StWait;
      StWait:  if (memdone) w_state_next = StAck;
      StAck:   w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // FSM outputs: memen only in REQ so the memory never sees a repeated start.
  always_comb begin
    memen  = (r_state == StReq);
    busy   = (r_state != StIdle);
    wbdone = (r_state == StAck) && (r_grant == GntWb);
    ddone  = (r_state == StAck) && (r_grant == GntD);
    idone  = (r_state == StAck) && (r_grant == GntI);
  end

  // Grant latch, memory-side operand registers and read-data capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_grant     <= GntWb;
      r_memadr    <= '0;
      r_memwdata  <= '0;
      r_membyteen <= '0;
      r_memrwb    <= 1'b1;
      r_rdata     <= '0;
    end else begin
      if (w_grant_en) begin
        r_grant <= w_gnt;
        case (w_gnt)
          GntWb: begin
            r_memadr    <= wbadr;
            r_memwdata  <= wbdata;
            r_membyteen <= wbbyteen;
            r_memrwb    <= 1'b0;
          end
          GntD: begin
            r_memadr    <= dadr;
            r_membyteen <= 4'b1111;
            r_memrwb    <= 1'b1;
          end
          default: begin
            r_memadr    <= iadr;
            r_membyteen <= 4'b1111;
            r_memrwb    <= 1'b1;
          end
        endcase
      end
      if ((r_state == StWait) && memdone && r_memrwb) begin
        r_rdata <= memrdata;
      end
    end
  end

  // Starvation counters: count waiting cycles, saturate, clear on grant or idle request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_dwait <= '0;
      r_iwait <= '0;
    end else begin
      if (!dreq || w_d_owner || (w_grant_en && (w_gnt == GntD))) begin
        r_dwait <= '0;
      end else if (r_dwait != {CW{1'b1}}) begin
        r_dwait <= r_dwait + 1'b1;
      end
      if (!ireq || w_i_owner || (w_grant_en && (w_gnt == GntI))) begin
        r_iwait <= '0;
      end else if (r_iwait != {CW{1'b1}}) begin
        r_iwait <= r_iwait + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios against a small mainmem-like model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        swc, wbreq, dreq, ireq;
  logic [29:0] wbadr, dadr, iadr;
  logic [31:0] wbdata;
  logic [3:0]  wbbyteen;
  logic        wbdone, ddone, idone, busy;
  logic [31:0] rdata, memwdata;
  logic [29:0] memadr;
  logic [3:0]  membyteen;
  logic        memrwb, memen, memdone;
  logic [31:0] memrdata = 32'h0;

  int checks = 0;
  int errors = 0;

  // Memory model: done drops one edge after en&done, rises one edge later.
  logic [31:0] mem [0:63];
  logic        mem_loaded = 1'b0;
  logic        m_done     = 1'b1;
  logic        force_en   = 1'b0;
  logic        force_val  = 1'b1;

  assign memdone = force_en ? force_val : m_done;

  always #5 clk = ~clk;

  mem_arbiter #(.STARVE(8), .CW(4)) u_dut (
    .clk(clk), .reset(reset), .swc(swc),
    .wbreq(wbreq), .wbadr(wbadr), .wbdata(wbdata), .wbbyteen(wbbyteen),
    .dreq(dreq), .dadr(dadr), .ireq(ireq), .iadr(iadr),
    .wbdone(wbdone), .ddone(ddone), .idone(idone), .rdata(rdata),
    .memadr(memadr), .memwdata(memwdata), .membyteen(membyteen),
    .memrwb(memrwb), .memen(memen), .memrdata(memrdata), .memdone(memdone),
    .busy(busy)
  );

  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int k = 0; k < 64; k++) mem[k] <= 32'h21212121;
      mem_loaded <= 1'b1;
    end else begin
      if (memen) memrdata <= mem[memadr[5:0]];
      if (force_en) begin
        m_done <= 1'b1;
      end else if (!m_done) begin
        m_done <= 1'b1;
      end else if (memen) begin
        m_done <= 1'b0;
        if (!memrwb) begin
          for (int b = 0; b < 4; b++)
            if (membyteen[b]) mem[memadr[5:0]][8*b +: 8] <= memwdata[8*b +: 8];
        end
      end
    end
  end

  // Done pulses must never overlap.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      checks++;
      if ((32'(wbdone) + 32'(ddone) + 32'(idone)) > 1) begin
        errors++;
        $display("FAIL done_exclusive got wb=%b d=%b i=%b want at most one", wbdone, ddone,
                 idone);
      end
    end
  end

  task automatic test_reset();
    reset = 1'b0; swc = 1'b0;
    wbreq = 1'b0; dreq = 1'b0; ireq = 1'b0;
    wbadr = '0; dadr = '0; iadr = '0; wbdata = '0; wbbyteen = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (memen !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl got memen=%b busy=%b want 0 0", memen, busy);
    end
    checks++;
    if (memrwb !== 1'b1) begin
      errors++; $display("FAIL reset_memrwb got %b want 1", memrwb);
    end
    checks++;
    if (memadr !== 30'h0 || memwdata !== 32'h0 || membyteen !== 4'h0 || rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_regs got adr=%h wd=%h be=%h rd=%h want zeros", memadr, memwdata,
               membyteen, rdata);
    end
    checks++;
    if ({wbdone, ddone, idone} !== 3'b000) begin
      errors++; $display("FAIL reset_done got %b want 000", {wbdone, ddone, idone});
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_read();
    dreq = 1'b1; dadr = 30'h4AD;
    @(negedge clk);
    checks++;
    if (memen !== 1'b1 || memrwb !== 1'b1 || membyteen !== 4'b1111 || memadr !== 30'h4AD) begin
      errors++;
      $display("FAIL read_issue got en=%b rwb=%b be=%b adr=%h want 1 1 1111 4ad", memen, memrwb,
               membyteen, memadr);
    end
    @(negedge clk);
    checks++;
    if (memen !== 1'b1) begin
      errors++; $display("FAIL read_en2 got %b want 1", memen);
    end
    @(negedge clk);
    checks++;
    if (memen !== 1'b0 || ddone !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL read_wait got en=%b done=%b busy=%b want 0 0 1", memen, ddone, busy);
    end
    @(negedge clk);
    checks++;
    if (ddone !== 1'b1 || rdata !== 32'h21212121) begin
      errors++; $display("FAIL read_done got done=%b rdata=%h want 1 21212121", ddone, rdata);
    end
    dreq = 1'b0;
    @(negedge clk);
    checks++;
    if (ddone !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL read_idle got done=%b busy=%b want 0 0", ddone, busy);
    end
  endtask

  task automatic test_single_write();
    int en_cnt = 0;
    int done_at = -1;
    wbreq = 1'b1; wbadr = 30'h4AD; wbdata = 32'hDDCCBBAA; wbbyteen = 4'b0011;
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk);
      if (memen === 1'b1) en_cnt++;
      if (n == 1) begin
        checks++;
        if (memrwb !== 1'b0 || membyteen !== 4'b0011 || memwdata !== 32'hDDCCBBAA) begin
          errors++;
          $display("FAIL write_issue got rwb=%b be=%b wd=%h want 0 0011 ddccbbaa", memrwb,
                   membyteen, memwdata);
        end
      end
      if (wbdone === 1'b1) begin
        if (done_at < 0) done_at = n;
        wbreq = 1'b0;
      end
    end
    checks++;
    if (en_cnt != 2) begin
      errors++; $display("FAIL write_en_cycles got %0d want 2", en_cnt);
    end
    checks++;
    if (done_at != 4) begin
      errors++; $display("FAIL write_done_cycle got %0d want 4", done_at);
    end
    wbreq = 1'b0;
    dreq = 1'b1; dadr = 30'h4AD;
    repeat (4) @(negedge clk);
    checks++;
    if (ddone !== 1'b1 || rdata !== 32'h2121BBAA) begin
      errors++; $display("FAIL write_readback got done=%b rdata=%h want 1 2121bbaa", ddone, rdata);
    end
    dreq = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_tie(input logic sw);
    int order [3];
    int want [3];
    int who;
    swc = sw;
    want[0] = 0;
    want[1] = sw ? 2 : 1;
    want[2] = sw ? 1 : 2;
    wbreq = 1'b1; wbadr = 30'h30; wbdata = 32'h1; wbbyteen = 4'b1111;
    dreq = 1'b1; dadr = 30'h31; ireq = 1'b1; iadr = 30'h32;
    for (int k = 0; k < 3; k++) begin
      who = -1;
      for (int c = 0; c < 20 && who < 0; c++) begin
        @(negedge clk);
        if (wbdone === 1'b1) begin who = 0; wbreq = 1'b0; end
        else if (ddone === 1'b1) begin who = 1; dreq = 1'b0; end
        else if (idone === 1'b1) begin who = 2; ireq = 1'b0; end
      end
      order[k] = who;
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (order[k] != want[k]) begin
        errors++;
        $display("FAIL tie_order swc=%b slot %0d got %0d want %0d (0=wb 1=d 2=i -1=timeout)",
                 sw, k, order[k], want[k]);
      end
    end
    wbreq = 1'b0; dreq = 1'b0; ireq = 1'b0; swc = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_starvation();
    int wb_cnt = 0;
    bit got_d = 1'b0;
    swc = 1'b0;
    wbreq = 1'b1; wbadr = 30'h20; wbdata = 32'h5; wbbyteen = 4'b1111;
    dreq = 1'b1; dadr = 30'h4AD;
    for (int c = 0; c < 60 && !got_d; c++) begin
      @(negedge clk);
      if (wbdone === 1'b1) wb_cnt++;
      if (ddone === 1'b1) begin
        got_d = 1'b1; dreq = 1'b0; wbreq = 1'b0;
      end
    end
    checks++;
    if (!got_d || wb_cnt != 2) begin
      errors++;
      $display("FAIL starve_grant got d_served=%b wb_before=%0d want 1 2", got_d, wb_cnt);
    end
    @(negedge clk);
    checks++;
    if (u_dut.r_dwait !== 4'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL starve_clear got dwait=%0d busy=%b want 0 0", u_dut.r_dwait, busy);
    end
  endtask

  task automatic test_holdoff();
    int bad = 0;
    bit got = 1'b0;
    force_en = 1'b1; force_val = 1'b1;
    dreq = 1'b1; dadr = 30'h4AD;
    repeat (8) begin
      @(negedge clk);
      if (memen !== 1'b1 || ddone !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL holdoff_stuck got %0d bad cycles want 0", bad);
    end
    force_val = 1'b0;
    @(negedge clk);
    checks++;
    if (memen !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL holdoff_accept got en=%b busy=%b want 0 1", memen, busy);
    end
    force_val = 1'b1;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge clk);
      if (ddone === 1'b1) got = 1'b1;
    end
    checks++;
    if (!got || rdata !== 32'h2121BBAA) begin
      errors++; $display("FAIL holdoff_done got done=%b rdata=%h want 1 2121bbaa", got, rdata);
    end
    dreq = 1'b0;
    force_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int spur = 0;
    bit got = 1'b0;
    dreq = 1'b1; dadr = 30'h5;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || memen !== 1'b0) begin
      errors++; $display("FAIL midrst_in_wait got busy=%b en=%b want 1 0", busy, memen);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (memen !== 1'b0 || memrwb !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midrst_outputs got en=%b rwb=%b busy=%b want 0 1 0", memen, memrwb, busy);
    end
    repeat (2) begin
      @(negedge clk);
      if ({wbdone, ddone, idone} !== 3'b000) spur++;
    end
    checks++;
    if (spur != 0) begin
      errors++; $display("FAIL midrst_no_done got %0d pulses want 0", spur);
    end
    reset = 1'b1;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge clk);
      if (ddone === 1'b1) got = 1'b1;
    end
    checks++;
    if (!got || rdata !== 32'h21212121) begin
      errors++; $display("FAIL midrst_fresh_read got done=%b rdata=%h want 1 21212121", got, rdata);
    end
    dreq = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_single_write();
    test_tie(1'b0);
    test_tie(1'b1);
    test_starvation();
    test_holdoff();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end

endmodule
